sched_queue_n: RTL and testbench

- Parametrised successor of the two-station scheduling queue.
- Holds DEPTH micro-op entries and picks the oldest hazard-free ready entry each cycle. The pick is registered into a single front stage that drives the ALU, the RF write address and the LSU request.
- Loads are two-phase. Phase 1 issues the LSU request, and the entry parks waiting for data. Phase 2 is the ALU operation using the returned data.
- Sits between instruction decode and ALU/AGU/LSU.

---
 rtl/sched_queue_n.sv | 220 ++++++++++++++++++++++
 tb/tb_sched_queue_n.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sched_queue_n.sv
// sched_queue_n: DEPTH-entry out-of-order scheduling queue feeding one
// registered front stage (ALU phase or LSU request).
//
// Ports:
//   clk, a_rst                 clock, asynchronous active-high reset
//   id_*                       decode side: feed strobe, operands, payload
//   id_req                     at least one entry is free
//   rf_a_adr, rf_b_adr         RF read addresses of this cycle's winner
//   fr_*                       front stage ALU-phase outputs
//   lsu_rq_*                   front stage memory-phase request
//   lsu_wait, sf_conflict      back-pressure from LSU / flag writeback
//   lsu_data_*                 load return (tag, data, strobe)
//
// Build option: SQ_LOAD_WAKEUP_BYPASS_EN makes a load entry woken by
// lsu_data_wb eligible in the same cycle, taking lsu_data_in directly.
module sched_queue_n #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 2,
  parameter int unsigned CTL_W = 8
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             id_feed,
  output logic             id_req,
  input  logic [2:0]       id_a_adr,
  input  logic [2:0]       id_b_adr,
  input  logic [3:0]       id_d_adr,
  input  logic             id_sf_wr,
  input  logic             id_ld,
  input  logic             id_st,
  input  logic [15:0]      id_k16,
  input  logic [CTL_W-1:0] id_ctl,
  output logic [2:0]       rf_a_adr,
  output logic [2:0]       rf_b_adr,
  output logic             fr_valid,
  output logic [CTL_W-1:0] fr_ctl,
  output logic [15:0]      fr_k16,
  output logic [3:0]       fr_d_adr,
  output logic             fr_sf_wr,
  output logic             lsu_rq_start,
  output logic             lsu_rq_cmd,
  output logic [TAG_W-1:0] lsu_rq_tag,
  input  logic             lsu_wait,
  input  logic             sf_conflict,
  input  logic [15:0]      lsu_data_in,
  input  logic [TAG_W-1:0] lsu_data_tag,
  input  logic             lsu_data_wb
);

  typedef enum logic [1:0] {S_FREE, S_PEND, S_LDWAIT} ent_state_t;

  ent_state_t       ent_state [DEPTH];
  ent_state_t       state_nxt [DEPTH];
  logic [2:0]       ent_a     [DEPTH];
  logic [2:0]       ent_b     [DEPTH];
  logic [3:0]       ent_d     [DEPTH];
  logic [15:0]      ent_k16   [DEPTH];
  logic [CTL_W-1:0] ent_ctl   [DEPTH];
  logic [DEPTH-1:0] ent_sf, ent_ld, ent_st;
  // older[i][j] = 1 : entry j is older than entry i
  logic [DEPTH-1:0] older     [DEPTH];

  logic [DEPTH-1:0] free, hit, pend_e, ld_e, mem_e, elig, free_now;
  logic [15:0]      k_e       [DEPTH];
  logic [TAG_W-1:0] sel, alloc_idx;
  logic             have_win, stall, issue, alloc;
  logic [3:0]       fr_d;
  logic             fr_sf_raw;

  // Effective per-entry view; with the bypass a woken load is treated as a
  // PEND ALU op carrying the returning data in this very cycle.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      free[i] = (ent_state[i] == S_FREE);
      hit[i]  = lsu_data_wb && (ent_state[i] == S_LDWAIT) && (lsu_data_tag == TAG_W'(i));
`ifdef SQ_LOAD_WAKEUP_BYPASS_EN
      pend_e[i] = (ent_state[i] == S_PEND) || hit[i];
      ld_e[i]   = ent_ld[i] & ~hit[i];
      k_e[i]    = hit[i] ? lsu_data_in : ent_k16[i];
`else
      pend_e[i] = (ent_state[i] == S_PEND);
      ld_e[i]   = ent_ld[i];
      k_e[i]    = ent_k16[i];
`endif
      mem_e[i] = pend_e[i] & (ld_e[i] | ent_st[i]);
    end
  end

  always_comb begin
    logic blocked;
    elig     = '0;
    sel      = '0;
    have_win = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (older[i][j] && !free[j]) begin
          blocked |= ent_d[j][3] && (ent_d[j][2:0] == ent_a[i] || ent_d[j][2:0] == ent_b[i]);
          blocked |= pend_e[j] && ent_d[i][3] &&
                     (ent_d[i][2:0] == ent_a[j] || ent_d[i][2:0] == ent_b[j]);
          blocked |= ent_d[i][3] && ent_d[j][3] && (ent_d[i][2:0] == ent_d[j][2:0]);
          blocked |= ent_sf[i] && ent_sf[j];
          blocked |= mem_e[i] && mem_e[j];
        end
      end
      elig[i] = pend_e[i] & ~blocked;
    end
    // Exactly one eligible entry has no eligible entry older than itself.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (elig[i] && ((older[i] & elig) == '0)) begin
        sel      = TAG_W'(i);
        have_win = 1'b1;
      end
    end
  end

  always_comb begin
    alloc_idx = '0;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (free[i-1]) alloc_idx = TAG_W'(i-1);
    end
  end

  assign id_req   = |free;
  assign alloc    = id_feed & id_req;
  assign stall    = (lsu_rq_start & lsu_wait) | (fr_valid & fr_sf_raw & sf_conflict);
  assign issue    = have_win & ~stall;
  assign rf_a_adr = have_win ? ent_a[sel] : '0;
  assign rf_b_adr = have_win ? ent_b[sel] : '0;
  assign fr_d_adr = {fr_d[3] & fr_valid, fr_d[2:0]};
  assign fr_sf_wr = fr_valid & fr_sf_raw & ~sf_conflict;

  // Allocation only ever targets a FREE entry, so it never collides with issue.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      state_nxt[i] = ent_state[i];
      free_now[i]  = 1'b0;
      if (alloc && alloc_idx == TAG_W'(i)) begin
        state_nxt[i] = S_PEND;
      end else if (issue && sel == TAG_W'(i)) begin
        if (mem_e[i] && ld_e[i]) begin
          state_nxt[i] = S_LDWAIT;
        end else begin
          state_nxt[i] = S_FREE;
          free_now[i]  = 1'b1;
        end
      end else if (hit[i]) begin
        state_nxt[i] = S_PEND;
      end
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_state[i] <= S_FREE;
        older[i]     <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        ent_state[r] <= state_nxt[r];
        for (int unsigned c = 0; c < DEPTH; c++) begin
          if (alloc && alloc_idx == TAG_W'(r)) begin
            older[r][c] <= ~free[c] & ~free_now[c];
          end else if (free_now[c] || (alloc && alloc_idx == TAG_W'(c))) begin
            older[r][c] <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (alloc && alloc_idx == TAG_W'(i)) begin
        ent_a[i]   <= id_a_adr;
        ent_b[i]   <= id_b_adr;
        ent_d[i]   <= id_d_adr;
        ent_sf[i]  <= id_sf_wr;
        ent_ld[i]  <= id_ld;
        ent_st[i]  <= id_st;
        ent_k16[i] <= id_k16;
        ent_ctl[i] <= id_ctl;
      end else if (hit[i]) begin
        ent_ld[i]  <= 1'b0;
        ent_k16[i] <= lsu_data_in;
      end
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      fr_valid     <= 1'b0;
      lsu_rq_start <= 1'b0;
      lsu_rq_cmd   <= 1'b0;
      lsu_rq_tag   <= '0;
      fr_ctl       <= '0;
      fr_k16       <= '0;
      fr_d         <= '0;
      fr_sf_raw    <= 1'b0;
    end else if (!stall) begin
      if (have_win) begin
        fr_valid     <= ~mem_e[sel];
        lsu_rq_start <= mem_e[sel];
        if (mem_e[sel]) begin
          lsu_rq_cmd <= ent_st[sel];
          lsu_rq_tag <= sel;
        end
        fr_ctl    <= ent_ctl[sel];
        fr_k16    <= k_e[sel];
        fr_d      <= ent_d[sel];
        fr_sf_raw <= ent_sf[sel];
      end else begin
        fr_valid     <= 1'b0;
        lsu_rq_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sched_queue_n.sv
// tb_sched_queue_n: directed stimulus for sched_queue_n with a sequence-number
// based reference model checked every cycle, plus literal expectations.
module tb_sched_queue_n;
  localparam int DEPTH = 4;
  localparam int TAG_W = 2;
  localparam int CTL_W = 8;
`ifdef SQ_LOAD_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic a_rst = 1'b0;
  logic id_feed = 1'b0, id_sf_wr = 1'b0, id_ld = 1'b0, id_st = 1'b0;
  logic [2:0] id_a_adr = '0, id_b_adr = '0;
  logic [3:0] id_d_adr = '0;
  logic [15:0] id_k16 = '0;
  logic [CTL_W-1:0] id_ctl = '0;
  logic lsu_wait = 1'b0, sf_conflict = 1'b0, lsu_data_wb = 1'b0;
  logic [15:0] lsu_data_in = '0;
  logic [TAG_W-1:0] lsu_data_tag = '0;
  logic id_req, fr_valid, fr_sf_wr, lsu_rq_start, lsu_rq_cmd;
  logic [2:0] rf_a_adr, rf_b_adr;
  logic [CTL_W-1:0] fr_ctl;
  logic [15:0] fr_k16;
  logic [3:0] fr_d_adr;
  logic [TAG_W-1:0] lsu_rq_tag;

  int checks = 0;
  int errors = 0;

  sched_queue_n #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CTL_W(CTL_W)) dut (
    .clk(clk), .a_rst(a_rst), .id_feed(id_feed), .id_req(id_req),
    .id_a_adr(id_a_adr), .id_b_adr(id_b_adr), .id_d_adr(id_d_adr),
    .id_sf_wr(id_sf_wr), .id_ld(id_ld), .id_st(id_st), .id_k16(id_k16),
    .id_ctl(id_ctl), .rf_a_adr(rf_a_adr), .rf_b_adr(rf_b_adr),
    .fr_valid(fr_valid), .fr_ctl(fr_ctl), .fr_k16(fr_k16), .fr_d_adr(fr_d_adr),
    .fr_sf_wr(fr_sf_wr), .lsu_rq_start(lsu_rq_start), .lsu_rq_cmd(lsu_rq_cmd),
    .lsu_rq_tag(lsu_rq_tag), .lsu_wait(lsu_wait), .sf_conflict(sf_conflict),
    .lsu_data_in(lsu_data_in), .lsu_data_tag(lsu_data_tag), .lsu_data_wb(lsu_data_wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Entry status: 0 free, 1 waiting to issue, 2 load parked for data.
  // Age is a monotonically increasing allocation number.
  int               m_st  [DEPTH];
  int               m_seq [DEPTH];
  logic [2:0]       m_a   [DEPTH];
  logic [2:0]       m_b   [DEPTH];
  logic [3:0]       m_d   [DEPTH];
  logic [15:0]      m_k   [DEPTH];
  logic [CTL_W-1:0] m_ctl [DEPTH];
  bit               m_sf  [DEPTH];
  bit               m_ld  [DEPTH];
  bit               m_so  [DEPTH];
  int               seq_ctr;
  bit mf_valid, mf_start, mf_cmd, mf_sf;
  int mf_tag;
  logic [CTL_W-1:0] mf_ctl;
  logic [15:0] mf_k;
  logic [3:0] mf_d;

  function automatic bit hit_m(int j);
    return m_st[j] == 2 && lsu_data_wb && (int'(lsu_data_tag) == j);
  endfunction

  function automatic bit pend_m(int j);
    return m_st[j] == 1 || (BYP && hit_m(j));
  endfunction

  function automatic bit memph(int j);
    return pend_m(j) && ((m_ld[j] && !(BYP && hit_m(j))) || m_so[j]);
  endfunction

  function automatic bit hazard(int i, int j);
    bit raw, war, waw;
    raw = m_d[j][3] && (m_d[j][2:0] == m_a[i] || m_d[j][2:0] == m_b[i]);
    war = pend_m(j) && m_d[i][3] && (m_d[i][2:0] == m_a[j] || m_d[i][2:0] == m_b[j]);
    waw = m_d[i][3] && m_d[j][3] && (m_d[i][2:0] == m_d[j][2:0]);
    return raw || war || waw || (m_sf[i] && m_sf[j]) || (memph(i) && memph(j));
  endfunction

  function automatic int pick();
    int best = -1;
    for (int i = 0; i < DEPTH; i++) begin
      bit ok = pend_m(i);
      for (int j = 0; j < DEPTH; j++)
        if (ok && j != i && m_st[j] != 0 && m_seq[j] < m_seq[i] && hazard(i, j)) ok = 0;
      if (ok && (best < 0 || m_seq[i] < m_seq[best])) best = i;
    end
    return best;
  endfunction

  function automatic bit any_free();
    for (int i = 0; i < DEPTH; i++) if (m_st[i] == 0) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge a_rst) begin : mdl
    int w, fi;
    bit stl, mem;
    bit hv [DEPTH];
    if (a_rst) begin
      for (int i = 0; i < DEPTH; i++) begin m_st[i] = 0; m_seq[i] = 0; end
      seq_ctr = 0;
      mf_valid = 0; mf_start = 0; mf_cmd = 0; mf_sf = 0; mf_tag = 0;
      mf_ctl = '0; mf_k = '0; mf_d = '0;
    end else begin
      w = pick();
      fi = -1;
      for (int i = 0; i < DEPTH; i++) begin
        if (m_st[i] == 0 && fi < 0) fi = i;
        hv[i] = hit_m(i);
      end
      stl = (mf_start && lsu_wait) || (mf_valid && mf_sf && sf_conflict);
      if (!stl) begin
        if (w >= 0) begin
          mem = memph(w);
          mf_valid = !mem;
          mf_start = mem;
          if (mem) begin mf_cmd = m_so[w]; mf_tag = w; end
          mf_ctl = m_ctl[w];
          mf_k   = hv[w] ? lsu_data_in : m_k[w];
          mf_d   = m_d[w];
          mf_sf  = m_sf[w];
          m_st[w] = (mem && m_ld[w]) ? 2 : 0;
        end else begin
          mf_valid = 0; mf_start = 0;
        end
      end
      for (int i = 0; i < DEPTH; i++)
        if (hv[i] && m_st[i] == 2) begin m_st[i] = 1; m_ld[i] = 0; m_k[i] = lsu_data_in; end
      if (id_feed && fi >= 0) begin
        m_st[fi] = 1; m_seq[fi] = seq_ctr; seq_ctr++;
        m_a[fi] = id_a_adr; m_b[fi] = id_b_adr; m_d[fi] = id_d_adr; m_k[fi] = id_k16;
        m_ctl[fi] = id_ctl; m_sf[fi] = id_sf_wr; m_ld[fi] = id_ld; m_so[fi] = id_st;
      end
    end
  end

  always @(negedge clk) begin : cmp
    int w;
    if (!a_rst) begin
      w = pick();
      chk("id_req", 32'(id_req), 32'(any_free()));
      chk("rf_a_adr", 32'(rf_a_adr), (w >= 0) ? 32'(m_a[w]) : 32'd0);
      chk("rf_b_adr", 32'(rf_b_adr), (w >= 0) ? 32'(m_b[w]) : 32'd0);
      chk("fr_valid", 32'(fr_valid), 32'(mf_valid));
      chk("lsu_rq_start", 32'(lsu_rq_start), 32'(mf_start));
      chk("fr_sf_wr", 32'(fr_sf_wr), 32'(mf_valid && mf_sf && !sf_conflict));
      chk("fr_d_adr_we", 32'(fr_d_adr[3]), 32'(mf_valid && mf_d[3]));
      if (mf_valid) begin
        chk("fr_d_adr", 32'(fr_d_adr), 32'(mf_d));
        chk("fr_k16", 32'(fr_k16), 32'(mf_k));
        chk("fr_ctl", 32'(fr_ctl), 32'(mf_ctl));
      end
      if (mf_start) begin
        chk("lsu_rq_cmd", 32'(lsu_rq_cmd), 32'(mf_cmd));
        chk("lsu_rq_tag", 32'(lsu_rq_tag), 32'(mf_tag));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [2:0] a, input logic [2:0] b, input logic [3:0] d,
                      input logic sf, input logic ld, input logic st, input logic [15:0] k);
    id_feed = 1'b1; id_a_adr = a; id_b_adr = b; id_d_adr = d;
    id_sf_wr = sf; id_ld = ld; id_st = st; id_k16 = k; id_ctl = {4'h5, d};
    tick();
    id_feed = 1'b0;
  endtask

  task automatic reset_checks();
    chk("rst fr_valid", 32'(fr_valid), 32'd0);
    chk("rst lsu_rq_start", 32'(lsu_rq_start), 32'd0);
    chk("rst lsu_rq_cmd", 32'(lsu_rq_cmd), 32'd0);
    chk("rst lsu_rq_tag", 32'(lsu_rq_tag), 32'd0);
    chk("rst fr_d_adr", 32'(fr_d_adr), 32'd0);
    chk("rst fr_sf_wr", 32'(fr_sf_wr), 32'd0);
    chk("rst fr_k16", 32'(fr_k16), 32'd0);
    chk("rst fr_ctl", 32'(fr_ctl), 32'd0);
    chk("rst rf_a_adr", 32'(rf_a_adr), 32'd0);
    chk("rst id_req", 32'(id_req), 32'd1);
  endtask

  task automatic do_reset();
    a_rst = 1'b1;
    id_feed = 1'b0; lsu_wait = 1'b0; sf_conflict = 1'b0; lsu_data_wb = 1'b0;
    #2;
    reset_checks();
    #1;
    a_rst = 1'b0;
    tick();
  endtask

  initial begin
    #1;
    do_reset();

    // Four independent ALU ops, issued in order two cycles after each feed.
    feed(3'd6, 3'd7, 4'd8, 0, 0, 0, 16'h0001);
    feed(3'd6, 3'd7, 4'd9, 0, 0, 0, 16'h0002);
    chk("t1 op0 valid", 32'(fr_valid), 32'd1);
    chk("t1 op0 d", 32'(fr_d_adr), 32'd8);
    feed(3'd6, 3'd7, 4'd10, 0, 0, 0, 16'h0003);
    chk("t1 op1 d", 32'(fr_d_adr), 32'd9);
    feed(3'd6, 3'd7, 4'd11, 0, 0, 0, 16'h0004);
    chk("t1 op2 d", 32'(fr_d_adr), 32'd10);
    tick();
    chk("t1 op3 d", 32'(fr_d_adr), 32'd11);
    chk("t1 op3 k", 32'(fr_k16), 32'h0004);
    tick();
    chk("t1 drained", 32'(fr_valid), 32'd0);

    // Store held in front by lsu_wait while the queue fills; extra feed dropped.
    do_reset();
    feed(3'd1, 3'd2, 4'd0, 0, 0, 1, 16'h0100);
    tick();
    chk("t2 st start", 32'(lsu_rq_start), 32'd1);
    chk("t2 st cmd", 32'(lsu_rq_cmd), 32'd1);
    chk("t2 st tag", 32'(lsu_rq_tag), 32'd0);
    lsu_wait = 1'b1;
    for (int n = 0; n < 4; n++) feed(3'd6, 3'd7, 4'(8 + n), 0, 0, 0, 16'(n));
    chk("t2 full", 32'(id_req), 32'd0);
    chk("t2 st held", 32'(lsu_rq_start), 32'd1);
    chk("t2 tag held", 32'(lsu_rq_tag), 32'd0);
    chk("t2 no alu", 32'(fr_valid), 32'd0);
    lsu_wait = 1'b0;
    feed(3'd6, 3'd7, 4'd12, 0, 0, 0, 16'hFFFF);
    chk("t2 resume", 32'(fr_valid), 32'd1);
    chk("t2 resume d", 32'(fr_d_adr), 32'd8);
    chk("t2 rq drop", 32'(lsu_rq_start), 32'd0);
    for (int n = 1; n < 4; n++) begin
      tick();
      chk("t2 drain d", 32'(fr_d_adr), 32'(8 + n));
    end
    tick();
    chk("t2 drop fed", 32'(fr_valid), 32'd0);

    // Load, parked, woken with 16'hBEEF.
    do_reset();
    feed(3'd1, 3'd1, 4'b1101, 0, 1, 0, 16'h0040);
    tick();
    chk("t3 ld start", 32'(lsu_rq_start), 32'd1);
    chk("t3 ld tag", 32'(lsu_rq_tag), 32'd0);
    chk("t3 ld cmd", 32'(lsu_rq_cmd), 32'd0);
    tick();
    chk("t3 parked", 32'(lsu_rq_start | fr_valid), 32'd0);
    lsu_data_wb = 1'b1; lsu_data_tag = 2'd0; lsu_data_in = 16'hBEEF;
    tick();
    lsu_data_wb = 1'b0;
    if (!BYP) begin
      chk("t3 wake delay", 32'(fr_valid), 32'd0);
      tick();
    end
    chk("t3 alu valid", 32'(fr_valid), 32'd1);
    chk("t3 alu k16", 32'(fr_k16), 32'hBEEF);
    chk("t3 alu d", 32'(fr_d_adr), 32'b1101);

    // RAW: op1 waits on load writing r3; younger op2 overtakes it.
    do_reset();
    feed(3'd0, 3'd0, 4'b1011, 0, 1, 0, 16'h0000);
    feed(3'd3, 3'd0, 4'b1100, 0, 0, 0, 16'h0011);
    feed(3'd0, 3'd0, 4'b1101, 0, 0, 0, 16'h0022);
    tick();
    chk("t4 op2 first", 32'(fr_d_adr), 32'b1101);
    tick();
    chk("t4 op1 blocked", 32'(fr_valid), 32'd0);
    lsu_data_wb = 1'b1; lsu_data_tag = 2'd0; lsu_data_in = 16'h1234;
    tick();
    lsu_data_wb = 1'b0;
    if (!BYP) tick();
    chk("t4 op0 alu d", 32'(fr_d_adr), 32'b1011);
    chk("t4 op0 alu k", 32'(fr_k16), 32'h1234);
    tick();
    chk("t4 op1 d", 32'(fr_d_adr), 32'b1100);

    // Flag-write conflict holds the front for one cycle.
    do_reset();
    feed(3'd1, 3'd1, 4'b1010, 1, 0, 0, 16'h00AA);
    feed(3'd4, 3'd4, 4'b1001, 0, 0, 0, 16'h00BB);
    chk("t5 sf op", 32'(fr_sf_wr), 32'd1);
    sf_conflict = 1'b1;
    #1;
    chk("t5 sf blocked", 32'(fr_sf_wr), 32'd0);
    tick();
    sf_conflict = 1'b0;
    #1;
    chk("t5 repeat d", 32'(fr_d_adr), 32'b1010);
    chk("t5 repeat sf", 32'(fr_sf_wr), 32'd1);
    tick();
    chk("t5 next d", 32'(fr_d_adr), 32'b1001);

    // Mid-stream reset with a parked load and three blocked entries.
    do_reset();
    feed(3'd0, 3'd0, 4'b1101, 0, 1, 0, 16'h0000);
    feed(3'd5, 3'd5, 4'd8, 0, 0, 0, 16'h0001);
    feed(3'd5, 3'd5, 4'd9, 0, 0, 0, 16'h0002);
    feed(3'd5, 3'd5, 4'd10, 0, 0, 0, 16'h0003);
    chk("t6 full", 32'(id_req), 32'd0);
    do_reset();
    lsu_data_wb = 1'b1; lsu_data_tag = 2'd1; lsu_data_in = 16'hDEAD;
    tick();
    lsu_data_wb = 1'b0;
    tick();
    chk("t6 no issue", 32'(fr_valid | lsu_rq_start), 32'd0);
    chk("t6 id_req", 32'(id_req), 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
